// File: rtl/uart_pkg.sv
// Shared UART definitions: state encodings and default timing constants
// used by both the receive path and the transmitter.
package uart_pkg;

    localparam int CLKS_PER_TICK_DEF = 54;
    localparam int OS_DEF            = 16;
    localparam int DATA_BITS_DEF     = 8;

    typedef logic [2:0] uart_state_t;

    localparam uart_state_t ST_IDLE  = 3'd0;
    localparam uart_state_t ST_START = 3'd1;
    localparam uart_state_t ST_DATA  = 3'd2;
    localparam uart_state_t ST_STOP  = 3'd3;
    localparam uart_state_t ST_BREAK = 3'd4;

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample strobe generator: counts 0..CLKS_PER_TICK-1 and pulses tick on
// the last count; clear holds the counter at zero while the line is idle.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int CLKS_PER_TICK = CLKS_PER_TICK_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int CW = (CLKS_PER_TICK > 1) ? $clog2(CLKS_PER_TICK) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_TICK - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear || (cnt_q == CNT_LAST)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Gated so a stale count on the first idle cycle cannot emit a strobe.
    assign tick = (cnt_q == CNT_LAST) && !clear;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronises rx, oversamples at OS ticks per bit and
// reassembles LSB-first frames, pulsing done or frame_err once per frame.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_TICK = CLKS_PER_TICK_DEF,
    parameter int OS            = OS_DEF,
    parameter int DATA_BITS     = DATA_BITS_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] dataout,
    output logic                 done,
    output logic                 frame_err,
    output logic                 busy,
    output logic                 tick
);

    localparam int SW = $clog2(OS);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [SW-1:0] SAMPLE_MID  = SW'(OS / 2 - 1);
    localparam logic [SW-1:0] SAMPLE_LAST = SW'(OS - 1);
    localparam logic [BW-1:0] BIT_LAST    = BW'(DATA_BITS - 1);

    logic                 rx_meta_q;
    logic                 rxs_q;
    logic                 rxs_prev_q;
    uart_state_t          state_q,   state_d;
    logic [SW-1:0]        sample_q,  sample_d;
    logic [BW-1:0]        bit_q,     bit_d;
    logic [DATA_BITS-1:0] shift_q,   shift_d;
    logic [DATA_BITS-1:0] dataout_q, dataout_d;
    logic                 done_q,    done_d;
    logic                 ferr_q,    ferr_d;

    uart_baud_tick #(
        .CLKS_PER_TICK(CLKS_PER_TICK)
    ) u_tick (
        .clk  (clk),
        .reset(reset),
        .clear(state_q == ST_IDLE),
        .tick (tick)
    );

    always_comb begin
        state_d   = state_q;
        sample_d  = sample_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        dataout_d = dataout_q;
        done_d    = 1'b0;
        ferr_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                sample_d = '0;
                bit_d    = '0;
                if (rxs_prev_q && !rxs_q) begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (tick) begin
                    if (sample_q == SAMPLE_MID) begin
                        sample_d = '0;
                        state_d  = rxs_q ? ST_IDLE : ST_DATA;
                    end else begin
                        sample_d = sample_q + 1'b1;
                    end
                end
            end
            ST_DATA: begin
                if (tick) begin
                    if (sample_q == SAMPLE_LAST) begin
                        sample_d = '0;
                        // Shifting in from the top lands bit 0 at the LSB after DATA_BITS samples.
                        shift_d  = {rxs_q, shift_q[DATA_BITS-1:1]};
                        bit_d    = bit_q + 1'b1;
                        if (bit_q == BIT_LAST) begin
                            state_d = ST_STOP;
                        end
                    end else begin
                        sample_d = sample_q + 1'b1;
                    end
                end
            end
            ST_STOP: begin
                if (tick) begin
                    if (sample_q == SAMPLE_LAST) begin
                        sample_d = '0;
                        if (rxs_q) begin
                            dataout_d = shift_q;
                            done_d    = 1'b1;
                            state_d   = ST_IDLE;
                        end else begin
                            ferr_d  = 1'b1;
                            state_d = ST_BREAK;
                        end
                    end else begin
                        sample_d = sample_q + 1'b1;
                    end
                end
            end
            ST_BREAK: begin
                if (rxs_q) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta_q  <= 1'b1;
            rxs_q      <= 1'b1;
            rxs_prev_q <= 1'b1;
            state_q    <= ST_IDLE;
            sample_q   <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            dataout_q  <= '0;
            done_q     <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            rx_meta_q  <= rx;
            rxs_q      <= rx_meta_q;
            rxs_prev_q <= rxs_q;
            state_q    <= state_d;
            sample_q   <= sample_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            dataout_q  <= dataout_d;
            done_q     <= done_d;
            ferr_q     <= ferr_d;
        end
    end

    assign dataout   = dataout_q;
    assign done      = done_q;
    assign frame_err = ferr_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
UART receive stage that sits directly downstream of FSMTX and consumes its serial line.
- Synchronises the asynchronous rx line and oversamples it at 16x the baud rate.
- Recovers 8N1 frames (start bit, 8 data bits LSB first, one stop bit) into parallel bytes.
- Flags a one-cycle done pulse per valid byte, or a framing error.
- Serves as the loopback checker for FSMTX and as the design's receive path.

Parameters:
- CLKS_PER_TICK, default 54: clk cycles per oversample tick (100 MHz / (115200 × 16) ≈ 54). Must be ≥ 2.
- OS, default 16: oversample ticks per bit. Must be even and ≥ 4.
- DATA_BITS, default 8: data bits per frame.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- rx  input  1  serial line; idles high; asynchronous to clk.
- dataout  output  DATA_BITS  last correctly received byte.
- done  output  1  one-clk pulse: dataout has just been updated with a valid frame.
- frame_err  output  1  one-clk pulse: stop bit sampled low.
- busy  output  1  high in any state other than IDLE.
- tick  output  1  oversample strobe, exported for debug and bench alignment.

Behaviour:
- Reset values: dataout = 0, done = 0, frame_err = 0, busy = 0, state = IDLE, all counters = 0. Both synchroniser flops reset to 1.
- rx passes through a 2-flop synchroniser; call the result rxs. All decisions use rxs, so the rx-to-decision delay is 2 clk.
- Tick generator:
  - Free-running counter from 0 to CLKS_PER_TICK-1.
  - tick is high for one clk when the counter equals CLKS_PER_TICK-1.
  - In IDLE the counter is held at 0, so the first tick after start detection lands CLKS_PER_TICK clk later.
- States: IDLE, START, DATA, STOP, BREAK.
- IDLE:
  - A falling edge on rxs (previous 1, current 0) moves to START.
  - sample_cnt and bit_cnt clear to 0.
- START:
  - Count ticks in sample_cnt.
  - When sample_cnt reaches OS/2-1 on a tick (mid start bit):
    - rxs = 0: go to DATA, sample_cnt = 0.
    - rxs = 1: treat as a glitch; return to IDLE with no output activity.
- DATA:
  - On each tick, sample_cnt increments; when it reaches OS-1, sample rxs into shift[bit_cnt] (LSB first), clear sample_cnt, and increment bit_cnt.
  - After DATA_BITS samples, go to STOP.
- STOP: at sample_cnt = OS-1 on a tick (mid stop bit):
  - rxs = 1: dataout ← shift and done = 1 on the next clk; go to IDLE.
  - rxs = 0: frame_err = 1 on the next clk; dataout is unchanged; go to BREAK.
- BREAK: stay until rxs = 1, then go to IDLE. This prevents a held-low line from being decoded as repeated 0x00 frames.
- done and frame_err are never high together and are never high for more than one clk.
- Latency: done rises 1 clk after the mid-stop-bit tick, about 9.5 bit periods plus 3 clk after the start-bit edge on rx.
- Back-to-back frames: the return to IDLE happens at mid stop bit, so a start edge immediately following the stop bit is caught.
- Asserting reset mid-frame aborts it: no done and no frame_err; outputs return to their reset values immediately.
- A falling edge arriving while the block is not in IDLE is ignored.
- Width rules:
  - sample_cnt is $clog2(OS) bits; bit_cnt is $clog2(DATA_BITS+1) bits.
  - The tick counter is $clog2(CLKS_PER_TICK) bits.
  - No counter wraps unintentionally; each clears explicitly as specified.

Decomposition:
- uart_pkg holds:
  - state encoding for IDLE/START/DATA/STOP/BREAK;
  - default constants OS = 16, DATA_BITS = 8, CLKS_PER_TICK = 54.
- FSMTX adopts the same package.
- One sub-module, uart_baud_tick (counter plus hold-clear input, tick output), shared with the TX side. The synchroniser stays inline.

Test Plan:
- Common setup for all scenarios: CLKS_PER_TICK = 4, OS = 16, so one bit = 64 clk; behavioural serial driver on rx.
- Single frame 0xB3 (10110011): expect dataout = 8'hB3 and exactly one done pulse. frame_err stays 0, and busy drops in the same clk that done rises.
- Back-to-back 0xCC then 0x00 with no idle gap: expect two done pulses about 640 clk apart, carrying dataout = 8'hCC and then 8'h00, with no missed start edge.
- Glitch: rx low for 3 ticks (12 clk), then high: expect return to IDLE with no done and no frame_err. A following frame 0x5A is received correctly.
- Framing error: send 0xA5 with stop bit = 0, held low for 2 more bit times:
  - expect one frame_err pulse, and dataout keeps its previous value;
  - busy stays high until rx returns high;
  - no further frame_err or done pulses while rx is held low.
- Reset mid-frame: assert reset during bit 4 of 0xFF. Expect outputs cleared immediately with no done; after release, 0x3C is received correctly.
- Loopback: FSMTX.tx feeds uart_rx.rx with matching baud. Send 0xB3 and then 0xCC; expect done with dataout equal to each transmitted byte in order.
